deser1_4: RTL and testbench

- Sequential serial-to-parallel demultiplexer. It is the receive end of a mux-based serializer that walks its select 00→01→10→11 over a 4-bit word.
- Accepts one bit per handshake, steers it to lane `sel` of an assembly register using an internal select counter, and presents the completed word on a registered valid/ready output.
- Sits between a serial link or bit-serial pipeline stage and word-wide pipeline logic.

---
 rtl/deser1_4.sv | 115 +++++++++++
 tb/tb_deser1_4.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/deser1_4.sv
// -----------------------------------------------------------------------------
// deser1_4 - serial-to-parallel demultiplexer (1 bit in, LANES bits out)
//
// Receive end of a mux-based serializer that walks its select 0,1,..,LANES-1.
// Each accepted bit is steered into lane `sel` of an assembly register. The
// LANES-th bit completes the word, which is presented on a registered
// valid/ready output. in_first realigns the frame to lane 0 and flags any
// partial word it throws away.
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous reset, active-high
//   in_bit     serial data bit
//   in_valid   in_bit is valid this cycle
//   in_first   in_bit is lane 0 of a new word (frame realign)
//   in_ready   block can accept a bit this cycle (combinational)
//   out_word   assembled word, lane i = i-th accepted bit
//   out_valid  out_word holds an unconsumed word
//   out_ready  downstream consumes out_word when out_valid && out_ready
//   sel        current select/lane counter (debug)
//   frame_err  one-cycle pulse: partial word discarded by in_first
// -----------------------------------------------------------------------------
module deser1_4 #(
    parameter int LANES = 4,
    parameter int SELW  = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_bit,
    input  logic             in_valid,
    input  logic             in_first,
    output logic             in_ready,
    output logic [LANES-1:0] out_word,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [SELW-1:0]  sel,
    output logic             frame_err
);

    localparam logic [SELW-1:0] LAST_SEL = SELW'(LANES - 1);

    logic [SELW-1:0]  sel_reg, sel_next;
    logic [LANES-1:0] asm_reg, asm_next;
    logic [LANES-1:0] out_word_reg, out_word_next;
    logic             out_valid_reg, out_valid_next;
    logic             frame_err_reg, frame_err_next;

    logic accept;
    logic complete;
    logic consume;

    // Only the word-completing bit is ever held off: it would otherwise
    // overwrite a word the consumer has not taken yet.
    assign in_ready = !((sel_reg == LAST_SEL) && out_valid_reg && !out_ready);
    assign accept   = in_valid && in_ready;
    assign complete = accept && !in_first && (sel_reg == LAST_SEL);
    assign consume  = out_valid_reg && out_ready;

    // Per-lane steering of the assembly register. in_first restarts the word
    // at lane 0 and clears the rest so stale bits never leak into a new word.
    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
            assign asm_next[gi] = !accept  ? asm_reg[gi] :
                                  in_first ? ((gi == 0) ? in_bit : 1'b0) :
                                  (sel_reg == SELW'(gi)) ? in_bit : asm_reg[gi];
        end
    endgenerate

    always_comb begin
        sel_next       = sel_reg;
        out_word_next  = out_word_reg;
        out_valid_next = out_valid_reg;
        frame_err_next = 1'b0;

        if (accept) begin
            if (in_first) begin
                sel_next       = SELW'(1);
                frame_err_next = (sel_reg != '0);
            end else begin
                // Natural SELW-bit wrap takes LANES-1 back to 0.
                sel_next = sel_reg + SELW'(1);
            end
        end

        // Completion wins over consume so back-to-back words have no bubble.
        if (complete) begin
            out_word_next  = {in_bit, asm_reg[LANES-2:0]};
            out_valid_next = 1'b1;
        end else if (consume) begin
            out_valid_next = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sel_reg       <= '0;
            asm_reg       <= '0;
            out_word_reg  <= '0;
            out_valid_reg <= 1'b0;
            frame_err_reg <= 1'b0;
        end else begin
            sel_reg       <= sel_next;
            asm_reg       <= asm_next;
            out_word_reg  <= out_word_next;
            out_valid_reg <= out_valid_next;
            frame_err_reg <= frame_err_next;
        end
    end

    assign out_word  = out_word_reg;
    assign out_valid = out_valid_reg;
    assign sel       = sel_reg;
    assign frame_err = frame_err_reg;

endmodule

// File: tb/tb_deser1_4.sv
// -----------------------------------------------------------------------------
// tb_deser1_4 - self-checking bench for deser1_4.
// Directed steps followed by random traffic, compared every cycle against a
// queue-based reference model of the word-assembly rules.
// -----------------------------------------------------------------------------
module tb_deser1_4;

    localparam int LANES = 4;
    localparam int SELW  = 2;

    logic             clk = 1'b0;
    logic             reset;
    logic             in_bit;
    logic             in_valid;
    logic             in_first;
    logic             in_ready;
    logic [LANES-1:0] out_word;
    logic             out_valid;
    logic             out_ready;
    logic [SELW-1:0]  sel;
    logic             frame_err;

    int checks = 0;
    int errors = 0;

    // Reference model state: bits collected for the current word, in order.
    bit               m_q[$];
    logic             m_valid;
    logic [LANES-1:0] m_word;
    logic             m_ferr;

    deser1_4 #(.LANES(LANES), .SELW(SELW)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_bit    (in_bit),
        .in_valid  (in_valid),
        .in_first  (in_first),
        .in_ready  (in_ready),
        .out_word  (out_word),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sel       (sel),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic model_ready();
        return !((m_q.size() == LANES - 1) && m_valid && !out_ready);
    endfunction

    // Advance the model by one clock edge using the currently driven inputs.
    task automatic model_clock();
        logic             acc;
        logic             cons;
        logic             done;
        logic [LANES-1:0] w;
        if (reset) begin
            m_q.delete();
            m_valid = 1'b0;
            m_word  = '0;
            m_ferr  = 1'b0;
        end else begin
            acc    = in_valid && model_ready();
            cons   = m_valid && out_ready;
            done   = 1'b0;
            w      = '0;
            m_ferr = 1'b0;
            if (acc) begin
                if (in_first) begin
                    m_ferr = (m_q.size() != 0);
                    m_q.delete();
                    m_q.push_back(in_bit);
                end else begin
                    m_q.push_back(in_bit);
                    if (m_q.size() == LANES) begin
                        foreach (m_q[i]) w[i] = m_q[i];
                        m_q.delete();
                        done = 1'b1;
                    end
                end
            end
            if (done) begin
                m_word  = w;
                m_valid = 1'b1;
            end else if (cons) begin
                m_valid = 1'b0;
            end
        end
    endtask

    task automatic check_regs();
        chk("sel", sel, m_q.size());
        chk("out_valid", out_valid, m_valid);
        chk("out_word", out_word, m_word);
        chk("frame_err", frame_err, m_ferr);
    endtask

    // One clock: drive, check in_ready mid-cycle, clock the model, check state.
    task automatic step(input logic b, input logic v, input logic f, input logic r);
        reset     = 1'b0;
        in_bit    = b;
        in_valid  = v;
        in_first  = f;
        out_ready = r;
        @(negedge clk);
        chk("in_ready", in_ready, model_ready());
        @(posedge clk);
        model_clock();
        #1;
        check_regs();
    endtask

    task automatic rst_step();
        reset    = 1'b1;
        in_valid = 1'b0;
        in_first = 1'b0;
        in_bit   = 1'b0;
        @(posedge clk);
        model_clock();
        #1;
        check_regs();
    endtask

    task automatic idle(input logic r);
        step(1'b0, 1'b0, 1'b0, r);
    endtask

    initial begin
        out_ready = 1'b1;
        m_valid   = 1'b0;
        m_word    = '0;
        m_ferr    = 1'b0;

        // Reset then basic word 0,1,0,1
        rst_step();
        rst_step();
        chk("reset_valid", out_valid, 1'b0);
        chk("reset_word", out_word, 4'b0000);
        chk("reset_sel", sel, 2'd0);
        step(0, 1, 0, 1); step(1, 1, 0, 1); step(0, 1, 0, 1); step(1, 1, 0, 1);
        chk("basic_word", out_word, 4'b1010);
        chk("basic_valid", out_valid, 1'b1);
        idle(1);
        chk("basic_drop", out_valid, 1'b0);

        // Stall gaps between bits 2 and 3
        step(1, 1, 0, 1); step(1, 1, 0, 1);
        idle(1); idle(1); idle(1);
        chk("stall_sel", sel, 2'd2);
        step(0, 1, 0, 1); step(1, 1, 0, 1);
        chk("stall_word", out_word, 4'b1011);
        idle(1);

        // Backpressure: A=1100 held, B's last bit waits for out_ready
        step(0, 1, 0, 0); step(0, 1, 0, 0); step(1, 1, 0, 0); step(1, 1, 0, 0);
        step(1, 1, 0, 0); step(0, 1, 0, 0); step(1, 1, 0, 0);
        step(0, 1, 0, 0);
        chk("bp_hold_word", out_word, 4'b1100);
        chk("bp_hold_sel", sel, 2'd3);
        step(0, 1, 0, 1);
        chk("bp_word_b", out_word, 4'b0101);
        chk("bp_valid_b", out_valid, 1'b1);
        idle(1);

        // Back-to-back words
        step(1, 1, 0, 1); step(0, 1, 0, 1); step(0, 1, 0, 1); step(0, 1, 0, 1);
        chk("b2b_word0", out_word, 4'b0001);
        step(0, 1, 0, 1); step(1, 1, 0, 1); step(1, 1, 0, 1); step(1, 1, 0, 1);
        chk("b2b_word1", out_word, 4'b1110);
        idle(1);

        // Realign mid-word, then in_first at sel=0
        step(1, 1, 0, 1); step(1, 1, 0, 1);
        step(0, 1, 1, 1);
        chk("realign_ferr", frame_err, 1'b1);
        step(1, 1, 0, 1);
        chk("realign_ferr_off", frame_err, 1'b0);
        step(1, 1, 0, 1); step(1, 1, 0, 1);
        chk("realign_word", out_word, 4'b1110);
        step(1, 1, 1, 1);
        chk("first_at_zero", frame_err, 1'b0);
        step(0, 1, 0, 1); step(0, 1, 0, 1); step(0, 1, 0, 1);
        chk("first_word", out_word, 4'b0001);
        idle(1);

        // Reset mid-operation with a held word
        step(1, 1, 0, 0); step(1, 1, 0, 0); step(1, 1, 0, 0); step(1, 1, 0, 0);
        step(1, 1, 0, 0); step(0, 1, 0, 0);
        rst_step();
        chk("mid_reset_valid", out_valid, 1'b0);
        chk("mid_reset_word", out_word, 4'b0000);
        chk("mid_reset_sel", sel, 2'd0);
        step(1, 1, 0, 1); step(0, 1, 0, 1); step(1, 1, 0, 1); step(0, 1, 0, 1);
        chk("post_reset_word", out_word, 4'b0101);

        // Random traffic against the model
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 59) == 0) begin
                rst_step();
            end else begin
                step(1'($urandom_range(0, 1)),
                     1'($urandom_range(0, 3) != 0),
                     1'($urandom_range(0, 9) == 0),
                     1'($urandom_range(0, 2) != 0));
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
